// File: rtl/interface_pkg.sv
// ============================================================================
// interface_pkg : AHB-Lite encodings and refill FSM states shared by burst logic
// Revision      : 1.0
// ============================================================================
`default_nettype none

package interface_pkg;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } burst_types_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } trans_types_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FILL  = 2'd2
    } refill_states_e;

    localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;
    localparam logic [2:0]  HSIZE_WORD          = 3'b010;

    // Word index within the 16-byte line; a count of 4 reuses the last beat's index.
    function automatic logic [1:0] wrap4_word(input logic [1:0] off, input logic [2:0] acnt);
        logic [1:0] step;
        step = acnt[2] ? 2'd3 : acnt[1:0];
        return off + step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wrap4_addr_gen.sv
// ============================================================================
// wrap4_addr_gen : combinational WRAP4 beat address (base, off, acnt) -> haddr
// Revision       : 1.0
// ============================================================================
`default_nettype none

module wrap4_addr_gen
    import interface_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        acnt_i,
    output logic [ADDR_W-1:0] haddr_o
);

    // Base is line aligned, so OR-ing the word index can never carry upward.
    assign haddr_o = base_i | ADDR_W'({wrap4_word(off_i, acnt_i), 2'b00});

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// icache_refill_ctrl : AHB-Lite WRAP4 critical-word-first I-cache line refill
// Build option       : ICACHE_CRIT_WORD_FWD_EN forwards the first beat early
// Revision           : 1.0
// ============================================================================
`default_nettype none

module icache_refill_ctrl
    import interface_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    output logic                miss_ack,
    output logic                busy,
    output logic                word_valid,
    output logic [DATA_W-1:0]   word_data,
    output logic                line_wr_en,
    output logic [ADDR_W-1:0]   line_wr_addr,
    output logic [4*DATA_W-1:0] line_wr_data,
    output logic [ADDR_W-1:0]   haddr,
    output logic [1:0]          htrans,
    output logic [2:0]          hburst,
    output logic [2:0]          hsize,
    output logic                hwrite,
    input  logic                hready,
    input  logic [DATA_W-1:0]   hrdata
);

    refill_states_e           state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [1:0]               off_q, off_d;
    logic [2:0]               acnt_q, acnt_d;
    logic [2:0]               dcnt_q, dcnt_d;
    logic [3:0][DATA_W-1:0]   slot_q;
    logic                     capture;
    logic [1:0]               slot_idx;

    assign slot_idx = off_q + dcnt_q[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            off_q   <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            if (capture) begin
                slot_q[slot_idx] <= hrdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        off_d    = off_q;
        acnt_d   = acnt_q;
        dcnt_d   = dcnt_q;
        miss_ack = 1'b0;
        htrans   = HTRANS_IDLE;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    miss_ack = 1'b1;
                    base_d   = miss_addr & ADDR_W'(WRAP4_BOUNDARY_MASK);
                    off_d    = miss_addr[3:2];
                    acnt_d   = 3'd0;
                    dcnt_d   = 3'd0;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                if (acnt_q != 3'd4) begin
                    htrans = (acnt_q == 3'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                end
                if (hready) begin
                    if (acnt_q != 3'd4) begin
                        acnt_d = acnt_q + 3'd1;
                    end
                    // A data phase is pending whenever more addresses went out than beats came back.
                    if (dcnt_q < acnt_q) begin
                        capture = 1'b1;
                        dcnt_d  = dcnt_q + 3'd1;
                        if (dcnt_q == 3'd3) begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    wrap4_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base_i  (base_q),
        .off_i   (off_q),
        .acnt_i  (acnt_q),
        .haddr_o (haddr)
    );

    assign busy         = (state_q != ST_IDLE);
    assign line_wr_en   = (state_q == ST_FILL);
    assign line_wr_addr = base_q;
    assign line_wr_data = slot_q;
    assign hburst       = HBURST_WRAP4;
    assign hsize        = HSIZE_WORD;
    assign hwrite       = 1'b0;

`ifdef ICACHE_CRIT_WORD_FWD_EN
    logic              fwd_valid_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= capture && (dcnt_q == 3'd0);
            if (capture && (dcnt_q == 3'd0)) begin
                fwd_data_q <= hrdata;
            end
        end
    end

    assign word_valid = fwd_valid_q;
    assign word_data  = fwd_data_q;
`else
    assign word_valid = (state_q == ST_FILL);
    assign word_data  = slot_q[off_q];
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// tb_icache_refill_ctrl : bench for icache_refill_ctrl with an AHB slave model
// Revision              : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         miss_ack;
    logic         busy;
    logic         word_valid;
    logic [31:0]  word_data;
    logic         line_wr_en;
    logic [31:0]  line_wr_addr;
    logic [127:0] line_wr_data;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic         hready = 1'b1;
    logic [31:0]  hrdata;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int fill_cyc = 0;
    logic [31:0] seed = 32'h1234_5678;

    icache_refill_ctrl #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .miss_ack     (miss_ack),
        .busy         (busy),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .line_wr_en   (line_wr_en),
        .line_wr_addr (line_wr_addr),
        .line_wr_data (line_wr_data),
        .haddr        (haddr),
        .htrans       (htrans),
        .hburst       (hburst),
        .hsize        (hsize),
        .hwrite       (hwrite),
        .hready       (hready),
        .hrdata       (hrdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // AHB slave: an accepted address phase becomes the data phase of the next cycle.
    logic        ph_valid_n = 1'b0;
    logic [31:0] ph_addr_n = '0;
    logic        hready_n = 1'b1;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr = '0;

    always @(negedge clk) begin
        ph_valid_n = hready && htrans[1];
        ph_addr_n  = haddr;
        hready_n   = hready;
    end

    always @(posedge clk) begin
        if (hready_n) begin
            pend_valid <= ph_valid_n;
            pend_addr  <= ph_addr_n;
        end
    end

    assign hrdata = (pend_valid && hready) ? mem_word(pend_addr) : (32'hDEAD_BEEF ^ seed);

    // mode 0: zero wait, mode 1: two wait cycles in the second data phase, mode 2: random waits
    task automatic run_miss(input logic [31:0] addr, input int mode, input bit hold_next,
                            input logic [31:0] next_addr);
        logic [31:0]  q_addr[$];
        logic [1:0]   q_trans[$];
        logic [31:0]  base, ea, line_addr, wv_data;
        logic [127:0] line_data, exp_line;
        logic [1:0]   off, prev_trans;
        logic [31:0]  prev_addr;
        bit           got, done, prev_stall;
        int           acks, wv_cnt, wv_cyc, rel, exp_fill, exp_wv;
        base = addr & 32'hFFFF_FFF0;
        off  = addr[3:2];
        acks = 0; wv_cnt = 0; wv_cyc = -1; wv_data = '0;
        line_addr = '0; line_data = '0;
        miss_addr = addr;
        miss_req  = 1'b1;
        hready    = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (miss_ack === 1'b1) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL ack_timeout addr=%h: no miss_ack, required one within 20 cycles", addr);
            miss_req = 1'b0;
            return;
        end
        if (hold_next) miss_addr = next_addr;
        else miss_req = 1'b0;
        done = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_trans = '0;
        for (int i = 0; i < 80 && !done; i++) begin
            rel = cyc - ack_cyc;
            if (mode == 1) hready = !(rel == 3 || rel == 4);
            else if (mode == 2) hready = ($urandom_range(0, 3) != 0);
            else hready = 1'b1;
            @(negedge clk);
            if (prev_stall) begin
                tests++;
                if (haddr !== prev_addr || htrans !== prev_trans) begin
                    failed++;
                    $display("FAIL stall_hold: haddr=%h htrans=%0d, required haddr=%h htrans=%0d",
                             haddr, htrans, prev_addr, prev_trans);
                end
            end
            prev_stall = !hready && (htrans != 2'd0);
            prev_addr  = haddr;
            prev_trans = htrans;
            if (hready && htrans[1]) begin
                q_addr.push_back(haddr);
                q_trans.push_back(htrans);
            end
            if (miss_ack === 1'b1) acks++;
            if (word_valid === 1'b1) begin
                wv_cnt++; wv_cyc = cyc; wv_data = word_data;
            end
            if (line_wr_en === 1'b1) begin
                done = 1'b1; fill_cyc = cyc;
                line_addr = line_wr_addr; line_data = line_wr_data;
            end
            @(posedge clk); #1;
        end
        hready = 1'b1;
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL fill_timeout addr=%h: no line_wr_en, required one within 80 cycles", addr);
            return;
        end
        tests++;
        if (acks != 0) begin
            failed++;
            $display("FAIL ack_while_busy: %0d acks during refill, required 0", acks);
        end
        tests++;
        if (q_addr.size() != 4) begin
            failed++;
            $display("FAIL beat_count: %0d address phases, required 4", q_addr.size());
        end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            ea = base | 32'(((int'(off) + i) % 4) * 4);
            tests++;
            if (q_addr[i] !== ea || q_trans[i] !== ((i == 0) ? 2'd2 : 2'd3)) begin
                failed++;
                $display("FAIL beat_addr[%0d]: haddr=%h htrans=%0d, required haddr=%h htrans=%0d",
                         i, q_addr[i], q_trans[i], ea, (i == 0) ? 2 : 3);
            end
        end
        for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = mem_word(base + 32'(4 * k));
        tests++;
        if (line_addr !== base || line_data !== exp_line) begin
            failed++;
            $display("FAIL line_write: addr=%h data=%h, required addr=%h data=%h",
                     line_addr, line_data, base, exp_line);
        end
        tests++;
        if (wv_cnt != 1 || wv_data !== mem_word({addr[31:2], 2'b00})) begin
            failed++;
            $display("FAIL crit_word: %0d pulses data=%h, required 1 pulse data=%h",
                     wv_cnt, wv_data, mem_word({addr[31:2], 2'b00}));
        end
        if (mode != 2) begin
            exp_fill = ack_cyc + ((mode == 1) ? 8 : 6);
`ifdef ICACHE_CRIT_WORD_FWD_EN
            exp_wv = ack_cyc + 3;
`else
            exp_wv = exp_fill;
`endif
            tests++;
            if (fill_cyc != exp_fill || wv_cyc != exp_wv) begin
                failed++;
                $display("FAIL latency: fill at T+%0d word at T+%0d, required fill T+%0d word T+%0d",
                         fill_cyc - ack_cyc, wv_cyc - ack_cyc, exp_fill - ack_cyc, exp_wv - ack_cyc);
            end
        end
        if (!hold_next) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || line_wr_en !== 1'b0) begin
                failed++;
                $display("FAIL after_fill: busy=%b line_wr_en=%b, required 0 0", busy, line_wr_en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        tests++;
        if (htrans !== 2'd0 || haddr !== 32'd0 || busy !== 1'b0 || miss_ack !== 1'b0 ||
            word_valid !== 1'b0 || line_wr_en !== 1'b0 || word_data !== 32'd0 ||
            line_wr_data !== 128'd0) begin
            failed++;
            $display("FAIL reset_state: htrans=%0d haddr=%h busy=%b ack=%b wv=%b we=%b wd=%h, required all zero",
                     htrans, haddr, busy, miss_ack, word_valid, line_wr_en, word_data);
        end
        tests++;
        if (hburst !== 3'd2 || hsize !== 3'b010 || hwrite !== 1'b0) begin
            failed++;
            $display("FAIL bus_constants: hburst=%0d hsize=%0d hwrite=%b, required 2 2 0",
                     hburst, hsize, hwrite);
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned;
        run_miss(32'h0000_2000, 0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        run_miss(32'h0000_1008, 0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_states;
        run_miss(32'h0000_2008, 1, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        int first_fill;
        run_miss(32'h0000_1104, 0, 1'b1, 32'h0000_3004);
        first_fill = fill_cyc;
        run_miss(32'h0000_3004, 0, 1'b0, 32'h0);
        tests++;
        if (ack_cyc != first_fill + 1) begin
            failed++;
            $display("FAIL back_to_back_ack: ack %0d cycles after fill, required 1", ack_cyc - first_fill);
        end
    endtask

    task automatic test_reset_abort;
        bit got, wrote;
        miss_addr = 32'h0000_4008;
        miss_req  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (miss_ack === 1'b1) got = 1'b1;
            @(posedge clk); #1;
        end
        miss_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (!got || htrans !== 2'd3) begin
            failed++;
            $display("FAIL abort_setup: ack=%b htrans=%0d at T+3, required ack 1 htrans 3", got, htrans);
        end
        rstn = 1'b0;
        #1;
        tests++;
        if (htrans !== 2'd0 || busy !== 1'b0 || line_wr_en !== 1'b0 || haddr !== 32'd0) begin
            failed++;
            $display("FAIL async_abort: htrans=%0d busy=%b we=%b haddr=%h, required 0 0 0 0",
                     htrans, busy, line_wr_en, haddr);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        wrote = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (line_wr_en !== 1'b0 || busy !== 1'b0) wrote = 1'b1;
        end
        tests++;
        if (wrote) begin
            failed++;
            $display("FAIL abort_quiet: activity after aborted burst, required none");
        end
        @(posedge clk); #1;
        run_miss(32'h0000_5004, 0, 1'b0, 32'h0);
    endtask

    task automatic test_crit_word;
        run_miss(32'h0000_100C, 0, 1'b0, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 8; n++) begin
            seed = $urandom;
            a    = $urandom;
            run_miss(a, 2, 1'b0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrap();
        test_wait_states();
        test_back_to_back();
        test_reset_abort();
        test_crit_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
AHB-Lite master-side refill sequencer for the I-cache.
- On a cache miss it issues one read WRAP4 burst, critical word first, starting at the missing word.
- It collects the four beats into a line buffer and writes the full 128-bit line into the cache array in a single cycle.
- It sits between the cache tag/hit logic (miss requester) and the AHB bus that feeds the transfer-tracking logic.

Parameters:
ADDR_W, 32, byte address width (haddr, miss_addr, line_wr_addr).
DATA_W, 32, AHB data width; line width is 4*DATA_W. Only 32 is supported.

Ports:
clk  in  1  clock.
rstn  in  1  reset.
miss_req  in  1  cache miss request; level, held until miss_ack.
miss_addr  in  ADDR_W  missing byte address; bits [1:0] ignored.
miss_ack  out  1  one-cycle pulse: miss accepted.
busy  out  1  refill in progress (state != IDLE).
word_valid  out  1  one-cycle pulse: requested word available.
word_data  out  DATA_W  requested (critical) word.
line_wr_en  out  1  one-cycle line write strobe.
line_wr_addr  out  ADDR_W  line-aligned address (miss_addr & 32'hFFFF_FFF0).
line_wr_data  out  4*DATA_W  slot i = word at line_wr_addr+4*i.
haddr  out  ADDR_W  AHB address.
htrans  out  2  AHB transfer type.
hburst  out  3  AHB burst type; constant WRAP4.
hsize  out  3  constant 3'b010 (word).
hwrite  out  1  constant 0.
hready  in  1  AHB ready.
hrdata  in  DATA_W  AHB read data.

Behaviour:
- Reset (rstn, asynchronous, active-low; clock clk):
  - state=IDLE, counters 0, htrans=IDLE, haddr=0.
  - miss_ack, word_valid, line_wr_en, busy all 0; word_data=0, line_wr_data=0.
  - Reset mid-burst aborts immediately; htrans=IDLE asynchronously; no line write.
- States: IDLE, BURST, FILL.
- IDLE:
  - htrans=IDLE.
  - If miss_req=1: miss_ack=1 this cycle; latch base=miss_addr&~0xF and off=miss_addr[3:2]; acnt=dcnt=0; go to BURST.
- BURST, address phase:
  - While acnt<4: htrans=NONSEQ when acnt==0, otherwise SEQ.
  - haddr = base | (((off+acnt) mod 4)<<2).
  - When acnt==4: htrans=IDLE, haddr holds its last value.
- BURST, on each hready=1 edge:
  - If acnt<4: acnt++.
  - If dcnt<acnt (data phase pending): slot[(off+dcnt) mod 4] <= hrdata; dcnt++.
- hready=0: haddr, htrans and both counters hold; no capture.
- When dcnt reaches 4, go to FILL.
- FILL (one cycle): line_wr_en=1 with line_wr_addr=base and line_wr_data=slots; next state IDLE.
- miss_req during BURST or FILL: ignored, no ack; the requester keeps it asserted.
- Back-to-back: a new miss can be acked in the IDLE cycle right after FILL.
- Wrap: the 4-bit offset wraps at the 16-byte boundary, never carrying into base. Example: 0x0000_1008 -> 0x1008, 0x100C, 0x1000, 0x1004.
- Zero-wait latency, ack at cycle T:
  - NONSEQ at T+1.
  - beats captured at edges ending T+2..T+5.
  - htrans=IDLE at T+5.
  - FILL at T+6.
  - IDLE at T+7.
- busy=1 in BURST and FILL.

Optional Feature:
Macro ICACHE_CRIT_WORD_FWD_EN.
- Defined: word_valid pulses the cycle after the first beat (dcnt 0->1) is captured, with word_data = that beat (T+3 at zero wait). It does not pulse again in FILL.
- Undefined: word_valid pulses in the FILL cycle, together with line_wr_en, with word_data = slot[off].

Decomposition:
- Shared package interface_pkg:
  - BURST_TYPES enum (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, ...).
  - TRANS_TYPES enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - WRAP4_BOUNDARY_MASK=32'hFFFF_FFF0, HSIZE_WORD=3'b010.
  - REFILL_STATES enum.
- One natural sub-module: wrap4_addr_gen, combinational, (base, off, acnt) -> haddr; reusable by other burst logic.

Test Plan:
- Aligned miss 0x0000_2000, hready=1 always, hrdata=A0..A3:
  - haddr 0x2000/04/08/0C with htrans NONSEQ, SEQ, SEQ, SEQ.
  - line_wr_en at T+6; line_wr_data={A3,A2,A1,A0}.
- Wrapped miss 0x0000_1008, beats D8, DC, D0, D4:
  - addresses 0x1008, 0x100C, 0x1000, 0x1004.
  - line slots {DC,D8,D4,D0} (slot3..0); word_data=D8.
- Wait states: hready=0 for 2 cycles during the 2nd data phase:
  - haddr/htrans held; no double capture.
  - line write delayed by exactly 2 cycles; data still correct.
- miss_req held during a refill, then a second miss 0x3004:
  - no ack while busy; ack in the first IDLE cycle after FILL.
  - second burst starts at 0x3004.
- rstn deasserted for one cycle at T+3 of a burst:
  - htrans=IDLE immediately; no line_wr_en; a fresh miss afterward completes normally.
- ICACHE_CRIT_WORD_FWD_EN on vs off, miss 0x100C:
  - on: word_valid at T+3 with the first beat.
  - off: word_valid at T+6 coincident with line_wr_en.
  - word_data identical in both.
